dumping_logic_gen2: RTL and testbench
=====================================

# dumping_logic_gen2

Parametrised successor to the per-channel dump controller in the correlation path. It generates dump timing from code-shift events, steps through a configurable number of correlators per dump, and tracks the coherent-integration count and overwrite protection. Dump records are queued in a small FIFO and drained through a valid/ready handshake to the coherent-sum consumer, so a stalled consumer no longer loses data silently.

## Interface
- COR_NUM, 8: correlators per channel, 2..16; last correlator index is COR_NUM-1
- COR_W, clog2(COR_NUM): correlator index width
- DATA_W, 16: I/Q accumulator width
- CNT_W, 16: dump counter width
- COH_W, 5: coherent counter width
- FIFO_DEPTH, 4: record FIFO depth, power of 2, at least 2

Ports:
- clk  in  1  clock; everything is on the rising edge
- rst  in  1  asynchronous, active-high reset
- overflow, shift_code  in  1 each  accumulator-overflow strobe; code-phase advance strobe
- coherent_number  in  COH_W  dumps per coherent period; 0 means 2^COH_W
- ms_cor_index  in  COR_W  correlator whose dump raises the ms-sum flag
- dump_length  in  CNT_W  shifts per dump; 0 means 2^CNT_W
- dump_count_en / _i / _o  in/in/out  1/CNT_W/CNT_W  state load and readback
- dumping_en / _i / _o  in/in/out  1/1/1  state load and readback
- current_cor_en / _i / _o  in/in/out  1/COR_W/COR_W  state load and readback; the _en strobe also marks a channel fill
- coherent_count_en / _i / _o  in/in/out  1/COH_W/COH_W  state load and readback
- i_acc, q_acc  in  DATA_W each  shifted accumulator values
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  consumer accepts the record at the FIFO head
- out_i, out_q  out  DATA_W each  record I/Q
- out_cor  out  COR_W  record correlator index
- out_new, out_ovw, out_ms  out  1 each  first dump of coherent period; overwrite flag; ms-sum flag
- dumping_valid  out  1  dumping_o & overflow_d
- coherent_done  out  1  sticky coherent-period-complete flag
- overwrite_protect  out  1  sticky overwrite flag
- fifo_overrun  out  1  sticky record-drop flag
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- `overflow_d` is `overflow` registered by one cycle. `dumping_valid` = `dumping_o & overflow_d`. `last` = `dumping_valid & (current_cor_o == COR_NUM-1)`.
- **Load priority.** Each `*_en` load takes priority over all internal updates of its own register.
- **Dump counter.** On `shift_code`, `dump_count_o` increments. When `next == dump_length`, it wraps to 0 and sets `dumping_o`.
- **dumping_o.** Set as above. Cleared on `last`; a clear on `last` wins over a set in the same cycle.
- **current_cor_o.** On `dumping_valid` it increments; on `last` it returns to 0.
- **coherent_count_o.** On `last` it increments. If `next == coherent_number`, it goes to 0 instead.
- **coherent_done.** Set on `dumping_valid & (coherent_count_o+1 == coherent_number)`. Cleared by `coherent_count_en`. Arithmetic is modulo 2^COH_W.
- **Overwrite tracking.** On the first `dumping_valid` after a fill, latch `first_cor` and set `first_valid`.
  - `ovw` = `first_valid & (first_cor == current_cor_o) & (coherent_count_o == 0) & dumping_valid`.
  - `overwrite_protect` is set by `ovw`.
  - `current_cor_en` clears `overwrite_protect`, `first_valid`, `first_cor` and `fifo_overrun`.
- **Record push.** On `dumping_valid`, push the record {`i_acc`, `q_acc`, `current_cor_o`, `coherent_count_o==0`, `ovw | overwrite_protect`, `current_cor_o == ms_cor_index`}.
- **Record pop.** A record is popped when `out_valid & out_ready`.
- **Full FIFO.** A push while full and not popping drops the new record and sets `fifo_overrun`. A push and a pop in the same cycle when full are both accepted.
- **Output stability.** Outputs show the head record. They hold steady while `out_valid & ~out_ready`.

## Timing
- Reset values: all outputs and internal state are 0, with the FIFO empty and `out_valid` = 0.
- Latency: `overflow` to `dumping_valid` is 1 cycle. `dumping_valid` to `out_valid` (FIFO previously empty) is 1 cycle. There is no combinational bypass.
- There are no combinational paths from `out_ready` to `out_valid` or to the data outputs.
- Asserting `rst` mid-dump clears the FIFO at once; in-flight records are discarded.
- `fifo_level` is updated in the same cycle as the push/pop, so it shows the new value on the next edge.
- Counters wrap modulo their width and never saturate.

## Test plan
- **Dump sequence.** COR_NUM=8, dump_length=3, coherent_number=2, out_ready=1, overflow pulsed every 2 cycles after dumping.
  - Expect records with cor 0..7, `out_new`=1 in the first period and 0 in the second.
  - `coherent_done` rises on the cor-0 dump of the second period.
  - `out_ms` is set only on cor == `ms_cor_index` (=4).
- **Backpressure.** out_ready=0 through 6 dumps with FIFO_DEPTH=4.
  - `fifo_level` = 4; `fifo_overrun` = 1 after the 5th dump.
  - On release, exactly cor 0..3 emerge in order.
- **Simultaneous push and pop at full.** FIFO full, out_ready=1 in the same cycle as `dumping_valid`.
  - No drop; `fifo_level` stays 4; `fifo_overrun` stays 0.
- **Overwrite protection.** Load current_cor_i=5 with coherent_count=0, then run a full sweep back to cor 5.
  - `out_ovw` = 1 on that record and on every later record.
  - A new `current_cor_en` clears `overwrite_protect`.
- **Wrap and zero values.** dump_length=0 with CNT_W=4: dumping is set after 16 shifts.
  - coherent_number=0 with COH_W=3: `coherent_done` is set after 8 sweeps.
- **Reset and load priority.** Assert rst mid-sweep with records queued: all outputs return to 0 asynchronously.
  - A `dumping_en` with `dumping_i`=1 in the same cycle as `last` leaves `dumping_o` = 1.

Source files
------------

// File: rtl/dumping_logic_gen2.sv
// Per-channel dump controller: derives dump timing from code shifts, steps the correlators,
// tracks coherent integration and overwrite state, and queues dump records for a valid/ready consumer.
module dumping_logic_gen2 #(
    parameter int COR_NUM    = 8,
    parameter int COR_W      = $clog2(COR_NUM),
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 16,
    parameter int COH_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          overflow,
    input  logic                          shift_code,
    input  logic [COH_W-1:0]              coherent_number,
    input  logic [COR_W-1:0]              ms_cor_index,
    input  logic [CNT_W-1:0]              dump_length,
    input  logic                          dump_count_en,
    input  logic [CNT_W-1:0]              dump_count_i,
    output logic [CNT_W-1:0]              dump_count_o,
    input  logic                          dumping_en,
    input  logic                          dumping_i,
    output logic                          dumping_o,
    input  logic                          current_cor_en,
    input  logic [COR_W-1:0]              current_cor_i,
    output logic [COR_W-1:0]              current_cor_o,
    input  logic                          coherent_count_en,
    input  logic [COH_W-1:0]              coherent_count_i,
    output logic [COH_W-1:0]              coherent_count_o,
    input  logic [DATA_W-1:0]             i_acc,
    input  logic [DATA_W-1:0]             q_acc,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_W-1:0]             out_i,
    output logic [DATA_W-1:0]             out_q,
    output logic [COR_W-1:0]              out_cor,
    output logic                          out_new,
    output logic                          out_ovw,
    output logic                          out_ms,
    output logic                          dumping_valid,
    output logic                          coherent_done,
    output logic                          overwrite_protect,
    output logic                          fifo_overrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int REC_W = 2 * DATA_W + COR_W + 3;
    localparam logic [COR_W-1:0] COR_LAST = COR_W'(COR_NUM - 1);

    typedef struct packed {
        logic [DATA_W-1:0] i;
        logic [DATA_W-1:0] q;
        logic [COR_W-1:0]  cor;
        logic              nw;
        logic              ovw;
        logic              ms;
    } rec_t;

    logic              overflow_d_r;
    logic [CNT_W-1:0]  dump_count_r;
    logic              dumping_r;
    logic [COR_W-1:0]  current_cor_r;
    logic [COH_W-1:0]  coherent_count_r;
    logic              coherent_done_r;
    logic              overwrite_protect_r;
    logic              fifo_overrun_r;
    logic              first_valid_r;
    logic [COR_W-1:0]  first_cor_r;
    logic              armed_r;
    rec_t              mem_r [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [LVL_W-1:0]  level_r;
    logic              out_valid_r;

    logic              dumping_valid_s;
    logic              last_s;
    logic [CNT_W-1:0]  shift_next_s;
    logic              wrap_s;
    logic [COH_W-1:0]  coh_next_s;
    logic              ovw_s;
    logic              full_s;
    logic              pop_s;
    logic              push_s;
    logic              drop_s;
    logic [LVL_W-1:0]  level_next_s;
    rec_t              push_rec_s;
    rec_t              head_s;

    assign dumping_valid_s = dumping_r & overflow_d_r;
    assign last_s          = dumping_valid_s & (current_cor_r == COR_LAST);
    assign shift_next_s    = dump_count_r + CNT_W'(1);
    // Comparing in CNT_W bits makes dump_length == 0 behave as 2^CNT_W.
    assign wrap_s          = shift_code & (shift_next_s == dump_length);
    assign coh_next_s      = coherent_count_r + COH_W'(1);
    assign ovw_s           = first_valid_r & (first_cor_r == current_cor_r)
                           & (coherent_count_r == {COH_W{1'b0}}) & dumping_valid_s;
    assign full_s          = (level_r == LVL_W'(FIFO_DEPTH));
    assign pop_s           = out_valid_r & out_ready;
    assign push_s          = dumping_valid_s & (~full_s | pop_s);
    assign drop_s          = dumping_valid_s & full_s & ~pop_s;
    assign head_s          = mem_r[rd_ptr_r];

    // Assemble the record captured on a dump
    always_comb begin
        push_rec_s     = {REC_W{1'b0}};
        push_rec_s.i   = i_acc;
        push_rec_s.q   = q_acc;
        push_rec_s.cor = current_cor_r;
        push_rec_s.nw  = (coherent_count_r == {COH_W{1'b0}});
        push_rec_s.ovw = ovw_s | overwrite_protect_r;
        push_rec_s.ms  = (current_cor_r == ms_cor_index);
    end

    // Next FIFO occupancy
    always_comb begin
        level_next_s = level_r;
        case ({push_s, pop_s})
            2'b10:   level_next_s = level_r + LVL_W'(1);
            2'b01:   level_next_s = level_r - LVL_W'(1);
            default: level_next_s = level_r;
        endcase
    end

    // Overflow strobe delay
    always_ff @(posedge clk or posedge rst) begin
        if (rst) overflow_d_r <= 1'b0;
        else     overflow_d_r <= overflow;
    end

    // Dump counter driven by code shifts
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                dump_count_r <= {CNT_W{1'b0}};
        else if (dump_count_en) dump_count_r <= dump_count_i;
        else if (wrap_s)        dump_count_r <= {CNT_W{1'b0}};
        else if (shift_code)    dump_count_r <= shift_next_s;
        else                    dump_count_r <= dump_count_r;
    end

    // Dumping window flag; the end-of-sweep clear beats a same-cycle set
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             dumping_r <= 1'b0;
        else if (dumping_en) dumping_r <= dumping_i;
        else if (last_s)     dumping_r <= 1'b0;
        else if (wrap_s)     dumping_r <= 1'b1;
        else                 dumping_r <= dumping_r;
    end

    // Correlator stepping within a dump
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  current_cor_r <= {COR_W{1'b0}};
        else if (current_cor_en)  current_cor_r <= current_cor_i;
        else if (last_s)          current_cor_r <= {COR_W{1'b0}};
        else if (dumping_valid_s) current_cor_r <= current_cor_r + COR_W'(1);
        else                      current_cor_r <= current_cor_r;
    end

    // Coherent-period counter and its sticky completion flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coherent_count_r <= {COH_W{1'b0}};
            coherent_done_r  <= 1'b0;
        end else if (coherent_count_en) begin
            coherent_count_r <= coherent_count_i;
            coherent_done_r  <= 1'b0;
        end else begin
            if (last_s)
                coherent_count_r <= (coh_next_s == coherent_number) ? {COH_W{1'b0}} : coh_next_s;
            if (dumping_valid_s && (coh_next_s == coherent_number))
                coherent_done_r <= 1'b1;
        end
    end

    // Overwrite tracking: the first dump after a fill marks where the channel wraps onto itself
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_valid_r       <= 1'b0;
            first_cor_r         <= {COR_W{1'b0}};
            armed_r             <= 1'b0;
            overwrite_protect_r <= 1'b0;
            fifo_overrun_r      <= 1'b0;
        end else if (current_cor_en) begin
            first_valid_r       <= 1'b0;
            first_cor_r         <= {COR_W{1'b0}};
            armed_r             <= 1'b1;
            overwrite_protect_r <= 1'b0;
            fifo_overrun_r      <= 1'b0;
        end else begin
            if (armed_r && dumping_valid_s) begin
                first_cor_r   <= current_cor_r;
                first_valid_r <= 1'b1;
                armed_r       <= 1'b0;
            end
            if (ovw_s)  overwrite_protect_r <= 1'b1;
            if (drop_s) fifo_overrun_r      <= 1'b1;
        end
    end

    // Record FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < FIFO_DEPTH; k++) mem_r[k] <= {REC_W{1'b0}};
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            level_r     <= {LVL_W{1'b0}};
            out_valid_r <= 1'b0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_rec_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            level_r     <= level_next_s;
            out_valid_r <= (level_next_s != {LVL_W{1'b0}});
        end
    end

    assign dump_count_o      = dump_count_r;
    assign dumping_o         = dumping_r;
    assign current_cor_o     = current_cor_r;
    assign coherent_count_o  = coherent_count_r;
    assign dumping_valid     = dumping_valid_s;
    assign coherent_done     = coherent_done_r;
    assign overwrite_protect = overwrite_protect_r;
    assign fifo_overrun      = fifo_overrun_r;
    assign fifo_level        = level_r;
    assign out_valid         = out_valid_r;
    assign out_i             = head_s.i;
    assign out_q             = head_s.q;
    assign out_cor           = head_s.cor;
    assign out_new           = head_s.nw;
    assign out_ovw           = head_s.ovw;
    assign out_ms            = head_s.ms;

endmodule

// File: tb/tb_dumping_logic_gen2.sv
// Directed bench for dumping_logic_gen2: expected records are queued as dumps are driven
// and compared as the consumer accepts them.
module tb_dumping_logic_gen2;

    localparam int COR_NUM = 8, COR_W = 3, DATA_W = 16, CNT_W = 4, COH_W = 3, FIFO_DEPTH = 4;
    localparam logic [COR_W-1:0] MS_COR = 3'd4;

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [2:0]  cor;
        logic        nw;
        logic        ovw;
        logic        ms;
    } rec_t;

    rec_t exp_q [$];
    rec_t head;
    int   checks = 0;
    int   errors = 0;

    logic clk = 1'b0;
    logic rst, overflow, shift_code;
    logic [COH_W-1:0]  coherent_number;
    logic [COR_W-1:0]  ms_cor_index;
    logic [CNT_W-1:0]  dump_length;
    logic              dump_count_en, dumping_en, dumping_i, current_cor_en, coherent_count_en;
    logic [CNT_W-1:0]  dump_count_i, dump_count_o;
    logic              dumping_o;
    logic [COR_W-1:0]  current_cor_i, current_cor_o;
    logic [COH_W-1:0]  coherent_count_i, coherent_count_o;
    logic [DATA_W-1:0] i_acc, q_acc, out_i, out_q;
    logic              out_valid, out_ready, out_new, out_ovw, out_ms;
    logic [COR_W-1:0]  out_cor;
    logic              dumping_valid, coherent_done, overwrite_protect, fifo_overrun;
    logic [2:0]        fifo_level;

    always #5 clk = ~clk;

    dumping_logic_gen2 #(
        .COR_NUM(COR_NUM), .DATA_W(DATA_W), .CNT_W(CNT_W), .COH_W(COH_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .overflow(overflow), .shift_code(shift_code),
        .coherent_number(coherent_number), .ms_cor_index(ms_cor_index), .dump_length(dump_length),
        .dump_count_en(dump_count_en), .dump_count_i(dump_count_i), .dump_count_o(dump_count_o),
        .dumping_en(dumping_en), .dumping_i(dumping_i), .dumping_o(dumping_o),
        .current_cor_en(current_cor_en), .current_cor_i(current_cor_i), .current_cor_o(current_cor_o),
        .coherent_count_en(coherent_count_en), .coherent_count_i(coherent_count_i),
        .coherent_count_o(coherent_count_o), .i_acc(i_acc), .q_acc(q_acc),
        .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
        .out_cor(out_cor), .out_new(out_new), .out_ovw(out_ovw), .out_ms(out_ms),
        .dumping_valid(dumping_valid), .coherent_done(coherent_done),
        .overwrite_protect(overwrite_protect), .fifo_overrun(fifo_overrun), .fifo_level(fifo_level)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_n(input int n);
        shift_code = 1'b1;
        repeat (n) tick();
        shift_code = 1'b0;
    endtask

    task automatic do_dump(input logic [2:0] cor, input logic nw, input logic ovw,
                           input logic keep, input logic rdy, input logic ld_dump);
        rec_t r;
        overflow = 1'b1;
        tick();
        overflow   = 1'b0;
        out_ready  = rdy;
        dumping_en = ld_dump;
        dumping_i  = ld_dump;
        i_acc      = 16'($urandom);
        q_acc      = 16'($urandom);
        check("dumping_valid", 32'(dumping_valid), 32'd1);
        check("current_cor", 32'(current_cor_o), 32'(cor));
        r.i = i_acc; r.q = q_acc; r.cor = cor; r.nw = nw; r.ovw = ovw; r.ms = (cor == MS_COR);
        if (keep) exp_q.push_back(r);
        tick();
        dumping_en = 1'b0;
        dumping_i  = 1'b0;
    endtask

    task automatic drain(input int budget);
        out_ready = 1'b1;
        for (int k = 0; k < budget && exp_q.size() != 0; k++) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        tick();
        check("drain_out_valid", 32'(out_valid), 32'd0);
    endtask

    // Consumer side: compare every accepted record with the queued expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_record", 32'(out_valid), 32'd0);
            end else begin
                head = exp_q.pop_front();
                check("out_cor", 32'(out_cor), 32'(head.cor));
                check("out_i", 32'(out_i), 32'(head.i));
                check("out_q", 32'(out_q), 32'(head.q));
                check("out_new", 32'(out_new), 32'(head.nw));
                check("out_ovw", 32'(out_ovw), 32'(head.ovw));
                check("out_ms", 32'(out_ms), 32'(head.ms));
            end
        end
    end

    initial begin
        rst = 1'b1; overflow = 1'b0; shift_code = 1'b0;
        coherent_number = 3'd2; ms_cor_index = MS_COR; dump_length = 4'd3;
        dump_count_en = 1'b0; dump_count_i = 4'd0; dumping_en = 1'b0; dumping_i = 1'b0;
        current_cor_en = 1'b0; current_cor_i = 3'd0; coherent_count_en = 1'b0; coherent_count_i = 3'd0;
        i_acc = 16'd0; q_acc = 16'd0; out_ready = 1'b1;
        repeat (2) tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_fifo_level", 32'(fifo_level), 32'd0);
        check("rst_dump_count", 32'(dump_count_o), 32'd0);
        check("rst_dumping", 32'(dumping_o), 32'd0);
        check("rst_cor", 32'(current_cor_o), 32'd0);
        check("rst_coh", 32'(coherent_count_o), 32'd0);
        check("rst_flags", {28'd0, coherent_done, overwrite_protect, fifo_overrun, dumping_valid}, 32'd0);
        check("rst_out_i", 32'(out_i), 32'd0);
        rst = 1'b0;
        tick();

        // Dump sequence: two coherent periods of eight correlators
        shift_n(2);
        check("dumping_early", 32'(dumping_o), 32'd0);
        check("dump_count_2", 32'(dump_count_o), 32'd2);
        shift_n(1);
        check("dumping_set", 32'(dumping_o), 32'd1);
        check("dump_count_wrap", 32'(dump_count_o), 32'd0);
        for (int p = 0; p < 2; p++) begin
            if (p == 1) shift_n(3);
            for (int c = 0; c < 8; c++) begin
                do_dump(3'(c), p == 0, 1'b0, 1'b1, 1'b1, 1'b0);
                if (p == 1 && c == 0) check("coherent_done_p2", 32'(coherent_done), 32'd1);
            end
            if (p == 0) begin
                check("coherent_done_p1", 32'(coherent_done), 32'd0);
                check("coh_count_p1", 32'(coherent_count_o), 32'd1);
                check("dumping_cleared", 32'(dumping_o), 32'd0);
            end else begin
                check("coh_count_p2", 32'(coherent_count_o), 32'd0);
            end
        end
        drain(20);

        // Backpressure: six dumps into a four-deep FIFO
        out_ready = 1'b0;
        shift_n(3);
        for (int c = 0; c < 6; c++) begin
            do_dump(3'(c), 1'b1, 1'b0, c < 4, 1'b0, 1'b0);
            if (c == 3) check("bp_overrun_4", 32'(fifo_overrun), 32'd0);
            if (c >= 3) check("bp_level", 32'(fifo_level), 32'd4);
            if (c == 4) check("bp_overrun_5", 32'(fifo_overrun), 32'd1);
        end
        drain(20);

        // Reset mid-sweep with a record queued
        do_dump(3'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(fifo_level), 32'd0);
        check("arst_cor", 32'(current_cor_o), 32'd0);
        check("arst_dumping", 32'(dumping_o), 32'd0);
        check("arst_overrun", 32'(fifo_overrun), 32'd0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        tick();

        // Simultaneous push and pop at full
        shift_n(3);
        for (int c = 0; c < 4; c++) do_dump(3'(c), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("full_level", 32'(fifo_level), 32'd4);
        do_dump(3'd4, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        check("pushpop_level", 32'(fifo_level), 32'd4);
        check("pushpop_overrun", 32'(fifo_overrun), 32'd0);
        drain(20);

        // Overwrite protection after a fill at correlator 5
        current_cor_en = 1'b1; current_cor_i = 3'd5;
        coherent_count_en = 1'b1; coherent_count_i = 3'd0; coherent_number = 3'd1;
        tick();
        current_cor_en = 1'b0; coherent_count_en = 1'b0;
        check("fill_cor", 32'(current_cor_o), 32'd5);
        check("fill_protect", 32'(overwrite_protect), 32'd0);
        for (int c = 5; c < 8; c++) do_dump(3'(c), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        shift_n(3);
        for (int c = 0; c < 8; c++) begin
            do_dump(3'(c), 1'b1, c >= 5, 1'b1, 1'b1, 1'b0);
            if (c == 4) check("protect_before", 32'(overwrite_protect), 32'd0);
            if (c == 5) check("protect_set", 32'(overwrite_protect), 32'd1);
        end
        shift_n(3);
        do_dump(3'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        drain(20);
        current_cor_en = 1'b1; current_cor_i = 3'd0;
        tick();
        current_cor_en = 1'b0;
        check("protect_cleared", 32'(overwrite_protect), 32'd0);

        // Zero means full range: dump_length=0 and coherent_number=0
        dumping_en = 1'b1; dumping_i = 1'b0; dump_count_en = 1'b1; dump_count_i = 4'd0;
        coherent_count_en = 1'b1; coherent_count_i = 3'd0; dump_length = 4'd0; coherent_number = 3'd0;
        tick();
        dumping_en = 1'b0; dump_count_en = 1'b0; coherent_count_en = 1'b0;
        check("zero_dumping", 32'(dumping_o), 32'd0);
        check("zero_done", 32'(coherent_done), 32'd0);
        shift_n(15);
        check("wrap15_dumping", 32'(dumping_o), 32'd0);
        check("wrap15_count", 32'(dump_count_o), 32'd15);
        shift_n(1);
        check("wrap16_dumping", 32'(dumping_o), 32'd1);
        check("wrap16_count", 32'(dump_count_o), 32'd0);
        dump_length = 4'd1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) shift_n(1);
            for (int c = 0; c < 8; c++) do_dump(3'(c), k == 0, 1'b0, 1'b1, 1'b1, 1'b0);
            check("coh_done_sweep", 32'(coherent_done), 32'(k == 7));
        end
        check("coh_wrap_count", 32'(coherent_count_o), 32'd0);
        drain(20);

        // dumping_en load beats the end-of-sweep clear; earlier fill at cor 0 now overwrites
        shift_n(1);
        for (int c = 0; c < 8; c++) do_dump(3'(c), 1'b1, 1'b1, 1'b1, 1'b1, c == 7);
        check("load_beats_last", 32'(dumping_o), 32'd1);
        check("last_cor_zero", 32'(current_cor_o), 32'd0);
        check("last_coh_inc", 32'(coherent_count_o), 32'd1);
        drain(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
